// File: rtl/safe_pkg.sv
// Shared definitions for the safe display: status encodings, seven-segment
// glyphs (active-low, bit order {g,f,e,d,c,b,a}) and the BCD glyph decoder.
package safe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_LOCKED   = 2'b01,
        ST_UNLOCKED = 2'b10,
        ST_ALARM    = 2'b11
    } status_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    // Decode one BCD digit; non-decimal codes render blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] s;
        case (nibble)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/safe_scan_timer.sv
// Scan and blink timebase.
//   clk, rst      : clock, synchronous active-high reset
//   clr_blink_i   : restart the blink phase (blink counter cleared, blink on)
//   scan_idx_o    : digit currently being driven (0 = rightmost)
//   round_tick_o  : high on the cycle scan_idx wraps back to 0
//   blink_on_o    : blink phase, high = visible
module safe_scan_timer
    import safe_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 64,
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_blink_i,
    output logic [IDX_W-1:0] scan_idx_o,
    output logic             round_tick_o,
    output logic             blink_on_o
);

    localparam int unsigned REF_W = $clog2(REFRESH_DIV);
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [REF_W-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_on_q, blink_on_d;
    logic             refresh_wrap, last_digit;

    assign refresh_wrap = (refresh_cnt_q == REF_W'(REFRESH_DIV - 1));
    assign last_digit   = (scan_idx_q == IDX_W'(NUM_DIGITS - 1));
    assign round_tick_o = refresh_wrap && last_digit;

    // Next-state: refresh divider, digit index, blink divider.
    always_comb begin
        refresh_cnt_d = refresh_wrap ? '0 : refresh_cnt_q + REF_W'(1);
        scan_idx_d    = scan_idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_on_d    = blink_on_q;
        if (refresh_wrap) begin
            scan_idx_d = last_digit ? '0 : scan_idx_q + IDX_W'(1);
        end
        // A blink restart beats a toggle landing on the same cycle.
        if (clr_blink_i) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (round_tick_o) begin
            if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt_q <= '0;
            scan_idx_q    <= '0;
            blink_cnt_q   <= '0;
            blink_on_q    <= 1'b1;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            scan_idx_q    <= scan_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_on_q    <= blink_on_d;
        end
    end

    assign scan_idx_o = scan_idx_q;
    assign blink_on_o = blink_on_q;

endmodule

// File: rtl/safe_display_scan.sv
// Time-multiplexed seven-segment driver for the safe status display.
//   clk, rst  : clock, synchronous active-high reset
//   status    : safe mode (IDLE / LOCKED / UNLOCKED / ALARM)
//   entry_bcd : keypad entry digits, nibble i -> digit i (digit 0 rightmost)
//   entry_len : count of valid entry digits, clamped to NUM_DIGITS
//   seg, dp   : active-low segments {g,f,e,d,c,b,a} and decimal point
//   an        : active-low digit enables, at most one low
module safe_display_scan
    import safe_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 64,
    localparam int unsigned LEN_W = $clog2(NUM_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              status,
    input  logic [4*NUM_DIGITS-1:0] entry_bcd,
    input  logic [LEN_W-1:0]        entry_len,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [IDX_W-1:0]      scan_idx;
    logic                  round_tick, blink_on;
    logic [1:0]            status_q;
    logic                  status_chg, blink_vis;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [LEN_W-1:0]      len_clamp;
    logic [3:0]            digit_bcd [NUM_DIGITS];
    logic                  is_last;

    assign status_chg = (status != status_q);
    // The restart is visible in the very cycle the mode changes.
    assign blink_vis  = blink_on | status_chg;

    safe_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .REFRESH_DIV(REFRESH_DIV),
        .BLINK_DIV  (BLINK_DIV)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clr_blink_i (status_chg),
        .scan_idx_o  (scan_idx),
        .round_tick_o(round_tick),
        .blink_on_o  (blink_on)
    );

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        assign digit_bcd[g] = entry_bcd[4*g +: 4];
    end

    assign len_clamp = (entry_len > LEN_W'(NUM_DIGITS)) ? LEN_W'(NUM_DIGITS) : entry_len;
    assign is_last   = (scan_idx == IDX_W'(NUM_DIGITS - 1));

    // Glyph, decimal point and enable for the digit being scanned.
    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        an_d  = ~(NUM_DIGITS'(1) << scan_idx);
        case (status_e'(status))
            ST_IDLE: begin
                seg_d = (LEN_W'(scan_idx) < len_clamp) ? bcd_to_seg(digit_bcd[scan_idx])
                                                       : SEG_DASH;
                dp_d  = !((scan_idx == '0) && (len_clamp == LEN_W'(NUM_DIGITS)));
            end
            ST_LOCKED:   seg_d = is_last ? SEG_L : SEG_DASH;
            ST_UNLOCKED: seg_d = is_last ? SEG_U : SEG_BLANK;
            ST_ALARM: begin
                if (blink_vis) begin
                    seg_d = SEG_E;
                end else begin
                    an_d = '1;
                end
            end
            default: seg_d = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
            an_q     <= '1;
            status_q <= ST_IDLE;
        end else begin
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
            status_q <= status;
        end
    end

    // A round tick must coincide with the last digit of the scan.
    always_ff @(posedge clk) begin
        if (!rst && round_tick) begin
            assert (scan_idx == IDX_W'(NUM_DIGITS - 1));
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_safe_display_scan.sv
// Self-checking bench for safe_display_scan with a cycle-count reference model.
module tb_safe_display_scan;

    localparam int N = 4;
    localparam int R = 4;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  status = 2'b00;
    logic [15:0] entry_bcd = '0;
    logic [2:0]  entry_len = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    always #5 clk = ~clk;

    safe_display_scan #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(R),
        .BLINK_DIV  (B)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .status   (status),
        .entry_bcd(entry_bcd),
        .entry_len(entry_len),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: edges since reset release, scan rounds completed
    // since the last blink restart, and the previously seen status.
    int         k = 0;
    int         rounds = 0;
    logic [1:0] prev_st = 2'b00;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Apply inputs for one clock and queue the output expected after that edge.
    task automatic drive(input logic r, input logic [1:0] st,
                         input logic [15:0] bcd, input logic [2:0] len);
        exp_t e;
        int   i, l;
        bit   vis, chg;
        @(negedge clk);
        rst       = r;
        status    = st;
        entry_bcd = bcd;
        entry_len = len;
        if (r) begin
            e       = '{seg: 7'b1111111, dp: 1'b1, an: 4'b1111};
            k       = 0;
            rounds  = 0;
            prev_st = 2'b00;
        end else begin
            i    = (k / R) % N;
            l    = (int'(len) > N) ? N : int'(len);
            chg  = (st != prev_st);
            vis  = chg || (((rounds / B) % 2) == 0);
            e.dp = 1'b1;
            e.an = ~(4'(1) << i);
            case (st)
                2'b00: begin
                    e.seg = (i < l) ? glyph(bcd[4*i +: 4]) : 7'b0111111;
                    e.dp  = !(i == 0 && l == N);
                end
                2'b01: e.seg = (i == N-1) ? 7'b1000111 : 7'b0111111;
                2'b10: e.seg = (i == N-1) ? 7'b1000001 : 7'b1111111;
                default: begin
                    e.seg = vis ? 7'b0000110 : 7'b1111111;
                    if (!vis) e.an = 4'b1111;
                end
            endcase
            if (chg) rounds = 0;
            else if ((k % (R*N)) == R*N - 1) rounds++;
            prev_st = st;
            k++;
        end
        exp_q.push_back(e);
    endtask

    task automatic hold(input int cycles, input logic [1:0] st,
                        input logic [15:0] bcd, input logic [2:0] len);
        for (int c = 0; c < cycles; c++) drive(1'b0, st, bcd, len);
    endtask

    // Monitor: every output update is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({seg, dp, an} !== e) begin
                    errors++;
                    $display("FAIL out t=%0t got seg=%b dp=%b an=%b want seg=%b dp=%b an=%b",
                             $time, seg, dp, an, e.seg, e.dp, e.an);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  st;
        logic [15:0] bcd;
        logic [2:0]  len;
        int          dur;

        for (int c = 0; c < 3; c++) drive(1'b1, 2'b00, 16'h0000, 3'd0);
        hold(16, 2'b00, 16'h0927, 3'd3);
        hold(16, 2'b00, 16'h0927, 3'd4);
        hold(16, 2'b00, 16'h0927, 3'd7);
        hold(16, 2'b00, 16'h0927, 3'd0);
        hold(16, 2'b01, 16'h0927, 3'd4);
        hold(16, 2'b10, 16'h0927, 3'd4);
        hold(80, 2'b11, 16'h0927, 3'd4);
        hold(1,  2'b00, 16'h0927, 3'd4);
        hold(42, 2'b11, 16'h0927, 3'd4);
        drive(1'b1, 2'b11, 16'h0927, 3'd4);
        hold(40, 2'b11, 16'h0927, 3'd4);
        hold(16, 2'b00, 16'h58C1, 3'd4);

        for (int s = 0; s < 60; s++) begin
            st  = 2'($urandom_range(0, 3));
            bcd = 16'($urandom);
            len = 3'($urandom_range(0, 7));
            dur = $urandom_range(1, 40);
            for (int c = 0; c < dur; c++) begin
                drive(($urandom_range(0, 99) == 0), st, bcd, len);
            end
        end

        @(negedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
